// File: rtl/reg_list_sequencer_pkg.sv
// Shared control-unit definitions for the register-list sequencer:
// sequencer state encoding, default register count and a popcount helper.
package reg_list_sequencer_pkg;

  // Default architectural register count (bitmap width).
  localparam int NUM_REGS_DEFAULT = 16;

  // Widest register bitmap the popcount helper can handle.
  localparam int POPCOUNT_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } seq_state_e;

  // Number of set bits in a bitmap; narrower bitmaps are zero-extended by the caller.
  function automatic logic [7:0] popcount(input logic [POPCOUNT_MAX_W-1:0] bits);
    logic [7:0] total;
    total = '0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      total = total + {7'd0, bits[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/reg_list_sequencer_if.sv
// Handshake bundle between instruction decode / control unit (master)
// and the register-list sequencer (slave).
interface reg_list_sequencer_if
  import reg_list_sequencer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
);

  logic                start;
  logic [NUM_REGS-1:0] reg_list;
  logic                descending;
  logic                next;

  logic [ADDR_W-1:0]   reg_address;
  logic                valid;
  logic                last;
  logic [CNT_W-1:0]    beat;
  logic [CNT_W-1:0]    count;
  logic                busy;
  logic                done;

  modport master (
    output start, reg_list, descending, next,
    input  reg_address, valid, last, beat, count, busy, done
  );

  modport slave (
    input  start, reg_list, descending, next,
    output reg_address, valid, last, beat, count, busy, done
  );

endinterface

// File: rtl/reg_list_sequencer_priority_encoder.sv
// Picks the lowest (ascending) or highest (descending) set bit of a mask
// and reports whether any bit, or exactly one bit, is set.
module reg_priority_encoder #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] i_mask,
  input  logic                i_descending,
  output logic [ADDR_W-1:0]   o_index,
  output logic                o_any,
  output logic                o_oneHotSingle
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [NUM_REGS-1:0] w_maskMinusOne;

  // Scan order decides the winner: the last set bit visited overwrites earlier ones.
  always_comb begin
    o_index = '0;
    if (i_descending) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_mask[i]) o_index = ADDR_W'(i);
      end
    end else begin
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
        if (i_mask[i]) o_index = ADDR_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero exactly when only one bit was set.
  always_comb begin
    w_maskMinusOne = i_mask - ONE;
    o_any          = |i_mask;
    o_oneHotSingle = o_any && ((i_mask & w_maskMinusOne) == '0);
  end

endmodule

// File: rtl/reg_list_sequencer.sv
// Register-list sequencer for block transfers (LDM/STM, push/pop).
// Latches a register bitmap on start and hands out the selected register
// indices one per accepted beat, with beat position and total count.
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input logic                 clk,
  input logic                 reset,
  reg_list_sequencer_if.slave bus
);

  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  seq_state_e          r_state;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_descending;
  logic [CNT_W-1:0]    r_beat;
  logic [CNT_W-1:0]    r_count;

  logic [ADDR_W-1:0]         w_index;
  logic                      w_anySet;
  logic                      w_single;
  logic                      w_valid;
  logic [NUM_REGS-1:0]       w_selectMask;
  logic [POPCOUNT_MAX_W-1:0] w_listWide;
  logic [CNT_W-1:0]          w_listCount;

  reg_priority_encoder #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_encoder (
    .i_mask         (r_pending),
    .i_descending   (r_descending),
    .o_index        (w_index),
    .o_any          (w_anySet),
    .o_oneHotSingle (w_single)
  );

  // Popcount of the incoming list, computed on a zero-extended copy (bitmaps up to 64 regs).
  always_comb begin
    w_listWide  = POPCOUNT_MAX_W'(bus.reg_list);
    w_listCount = CNT_W'(popcount(w_listWide));
  end

  // Outputs decode the registered state and the pending bitmap.
  always_comb begin
    w_valid         = (r_state == ST_ACTIVE) && w_anySet;
    w_selectMask    = ONE << w_index;
    bus.reg_address = w_index;
    bus.valid       = w_valid;
    bus.last        = w_valid && w_single;
    bus.beat        = r_beat;
    bus.count       = r_count;
    bus.busy        = (r_state != ST_IDLE);
    bus.done        = (r_state == ST_DONE);
  end

  // Sequencer FSM: latch on start, retire one register per accepted beat, pulse done once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_descending <= 1'b0;
      r_beat       <= '0;
      r_count      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pending    <= bus.reg_list;
            r_descending <= bus.descending;
            r_count      <= w_listCount;
            r_beat       <= '0;
            r_state      <= (|bus.reg_list) ? ST_ACTIVE : ST_DONE;
          end
        end
        ST_ACTIVE: begin
          if (w_valid && bus.next) begin
            r_pending <= r_pending & ~w_selectMask;
            r_beat    <= r_beat + CNT_W'(1);
            if (w_single) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Scoreboard bench for reg_list_sequencer: the stimulus side queues the
// expected beats/done pulses, a negedge monitor pops and compares them.
module tb_reg_list_sequencer;

  localparam int NR = 16;

  typedef struct {
    bit isDone;
    int addr;
    int beat;
    bit last;
    int count;
    int rel;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   startCyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];
  exp_t monExp;

  reg_list_sequencer_if #(.NUM_REGS(NR)) bus ();

  reg_list_sequencer #(.NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to time events relative to the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushBeat(input int addr, input int beat, input bit last, input int count, input int rel);
    exp_t e;
    e.isDone = 1'b0; e.addr = addr; e.beat = beat; e.last = last; e.count = count; e.rel = rel;
    expQ.push_back(e);
  endtask

  task automatic pushDone(input int count, input int rel);
    exp_t e;
    e.isDone = 1'b1; e.addr = 0; e.beat = count; e.last = 1'b0; e.count = count; e.rel = rel;
    expQ.push_back(e);
  endtask

  // Issues start for one cycle, then scrambles list/direction to prove they were latched.
  task automatic applyStimulus(input logic [NR-1:0] list, input logic desc);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.reg_list   = list;
    bus.descending = desc;
    startCyc       = cyc + 1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.reg_list   = ~list;
    bus.descending = ~desc;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_regAddress"}, int'(bus.reg_address), 0);
    checkOutput({tag, "_valid"}, int'(bus.valid), 0);
    checkOutput({tag, "_last"}, int'(bus.last), 0);
    checkOutput({tag, "_beat"}, int'(bus.beat), 0);
    checkOutput({tag, "_count"}, int'(bus.count), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_done"}, int'(bus.done), 0);
  endtask

  // Monitor: every accepted beat or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && (bus.done || (bus.valid && bus.next))) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedEvent: got done=%0d valid=%0d addr=%0d, expected no event (cycle %0d)",
                 bus.done, bus.valid, bus.reg_address, cyc);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("eventKind", int'(bus.done), int'(monExp.isDone));
        checkOutput("eventCycle", cyc - startCyc, monExp.rel);
        checkOutput("count", int'(bus.count), monExp.count);
        checkOutput("beat", int'(bus.beat), monExp.beat);
        checkOutput("last", int'(bus.last), int'(monExp.last));
        if (!monExp.isDone) checkOutput("regAddress", int'(bus.reg_address), monExp.addr);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    bus.start      = 1'b0;
    bus.reg_list   = '0;
    bus.descending = 1'b0;
    bus.next       = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset    = 1'b0;
    bus.next = 1'b1;

    pushBeat(0, 0, 0, 3, 0);
    pushBeat(2, 1, 0, 3, 1);
    pushBeat(15, 2, 1, 3, 2);
    pushDone(3, 3);
    applyStimulus(16'h8005, 1'b0);
    waitDrain(20);

    pushBeat(15, 0, 0, 3, 0);
    pushBeat(2, 1, 0, 3, 1);
    pushBeat(0, 2, 1, 3, 2);
    pushDone(3, 3);
    applyStimulus(16'h8005, 1'b1);
    waitDrain(20);

    pushDone(0, 0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("emptyBusyFirst", int'(bus.busy), 1);
    checkOutput("emptyValid", int'(bus.valid), 0);
    @(posedge clk); #1;
    checkOutput("emptyBusyAfter", int'(bus.busy), 0);
    waitDrain(10);

    for (int i = 0; i < 16; i++) pushBeat(i, i, (i == 15), 16, i);
    pushDone(16, 16);
    applyStimulus(16'hFFFF, 1'b0);
    waitDrain(40);

    bus.next = 1'b0;
    pushBeat(0, 0, 0, 2, 1);
    pushBeat(8, 1, 1, 2, 3);
    pushDone(2, 4);
    applyStimulus(16'h0101, 1'b0);
    checkOutput("stallValid", int'(bus.valid), 1);
    checkOutput("stallAddr0", int'(bus.reg_address), 0);
    @(posedge clk); #1;
    checkOutput("stallHoldAddr0", int'(bus.reg_address), 0);
    checkOutput("stallHoldBeat0", int'(bus.beat), 0);
    bus.next = 1'b1;
    @(posedge clk); #1;
    bus.next = 1'b0;
    checkOutput("stallAddr8", int'(bus.reg_address), 8);
    checkOutput("stallBeat1", int'(bus.beat), 1);
    checkOutput("stallLast", int'(bus.last), 1);
    @(posedge clk); #1;
    bus.next = 1'b1;
    waitDrain(20);

    pushBeat(11, 0, 0, 2, 0);
    pushBeat(10, 1, 1, 2, 1);
    pushDone(2, 2);
    applyStimulus(16'h0C00, 1'b1);
    bus.start      = 1'b1;
    bus.reg_list   = 16'h0003;
    bus.descending = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDrain(20);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idleBusy", int'(bus.busy), 0);
    checkOutput("idleValid", int'(bus.valid), 0);

    pushBeat(4, 0, 0, 4, 0);
    pushBeat(5, 1, 0, 4, 1);
    applyStimulus(16'h00F0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset    = 1'b1;
    bus.next = 1'b0;
    @(posedge clk); #1;
    checkResetValues("midReset");
    reset    = 1'b0;
    bus.next = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abortQueue", expQ.size(), 0);
    expQ.delete();

    pushBeat(4, 0, 0, 4, 0);
    pushBeat(5, 1, 0, 4, 1);
    pushBeat(6, 2, 0, 4, 2);
    pushBeat(7, 3, 1, 4, 3);
    pushDone(4, 4);
    applyStimulus(16'h00F0, 1'b0);
    waitDrain(20);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
